// File: rtl/rsa_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rsa_pkg : shared types and helpers for the Montgomery modexp engine
// Rev 1.0
// ----------------------------------------------------------------------------
package rsa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_LOOP = 2'd2,
    ST_POST = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    OP_ONE  = 3'd0,
    OP_BASE = 3'd1,
    OP_R2   = 3'd2,
    OP_PM   = 3'd3,
    OP_RM   = 3'd4
  } opsel_e;

  // One issue cycle plus a multiplier run of width+2 cycles.
  function automatic int phase_len(input int width);
    return width + 3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mmm_serial_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mmm_serial_unit : bit-serial Montgomery multiplier, r = a*b*2^-WIDTH mod n
// Rev 1.0
// ----------------------------------------------------------------------------
module mmm_serial_unit
  import rsa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] r,
  output logic             done
);

  // Iterations per product: the phase minus issue, load and subtract cycles.
  localparam int ITERS = phase_len(WIDTH) - 3;
  localparam int CW    = $clog2(ITERS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ITERS);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH+1:0] s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             done_q, done_d;

  logic [WIDTH+1:0] w_t;
  logic [WIDTH+1:0] w_u;
  logic [WIDTH+1:0] w_sub;

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    n_d    = n_q;
    r_d    = r_q;
    s_d    = s_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;

    // S stays below 2N, so S + a_i*B + q*N < 4N fits in WIDTH+2 bits.
    w_t   = s_q + (a_q[0] ? {2'b00, b_q} : '0);
    w_u   = w_t + (w_t[0] ? {2'b00, n_q} : '0);
    w_sub = s_q - {2'b00, n_q};

    if (start && !run_q) begin
      a_d   = a;
      b_d   = b;
      n_d   = n;
      s_d   = '0;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q == CNT_LAST) begin
        r_d    = (s_q >= {2'b00, n_q}) ? w_sub[WIDTH-1:0] : s_q[WIDTH-1:0];
        run_d  = 1'b0;
        done_d = 1'b1;
      end else begin
        s_d   = w_u >> 1;
        a_d   = a_q >> 1;
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (clear) begin
      a_d    = '0;
      b_d    = '0;
      n_d    = '0;
      r_d    = '0;
      s_d    = '0;
      cnt_d  = '0;
      run_d  = 1'b0;
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      a_q    <= '0;
      b_q    <= '0;
      n_q    <= '0;
      r_q    <= '0;
      s_q    <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else if (ena) begin
      a_q    <= a_d;
      b_q    <= b_d;
      n_q    <= n_d;
      r_q    <= r_d;
      s_q    <= s_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign r    = r_q;
  assign done = done_q;

endmodule
`default_nettype wire

// File: rtl/rsa_modexp_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rsa_modexp_unit : handshake-driven Montgomery modular exponentiation engine
// Rev 1.0
// ----------------------------------------------------------------------------
module rsa_modexp_unit
  import rsa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] expo,
  input  logic [WIDTH-1:0] modulus,
  input  logic [WIDTH-1:0] r2,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic             pend_q, pend_d;
  logic             mstart_q, mstart_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] expo_q, expo_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic [WIDTH-1:0] r2_q, r2_d;
  logic [WIDTH-1:0] pm_q, pm_d;
  logic [WIDTH-1:0] rm_q, rm_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  opsel_e           sq_a_sel, sq_b_sel, mu_a_sel, mu_b_sel;
  logic [WIDTH-1:0] sq_a, sq_b, mu_a, mu_b, sq_r, mu_r;
  logic             sq_start, sq_done, mu_done, phase_done;

  function automatic logic [WIDTH-1:0] pick(input opsel_e sel,
                                            input logic [WIDTH-1:0] bv,
                                            input logic [WIDTH-1:0] rv,
                                            input logic [WIDTH-1:0] pv,
                                            input logic [WIDTH-1:0] mv);
    case (sel)
      OP_BASE: pick = bv;
      OP_R2:   pick = rv;
      OP_PM:   pick = pv;
      OP_RM:   pick = mv;
      default: pick = ONE;
    endcase
  endfunction

  always_comb begin
    sq_a_sel = OP_PM;
    sq_b_sel = OP_PM;
    mu_a_sel = OP_RM;
    mu_b_sel = OP_PM;
    case (state_q)
      ST_PRE: begin
        sq_a_sel = OP_BASE;
        sq_b_sel = OP_R2;
        mu_a_sel = OP_ONE;
        mu_b_sel = OP_R2;
      end
      ST_POST: begin
        mu_a_sel = OP_ONE;
        mu_b_sel = OP_RM;
      end
      default: ;
    endcase
    sq_a = pick(sq_a_sel, base_q, r2_q, pm_q, rm_q);
    sq_b = pick(sq_b_sel, base_q, r2_q, pm_q, rm_q);
    mu_a = pick(mu_a_sel, base_q, r2_q, pm_q, rm_q);
    mu_b = pick(mu_b_sel, base_q, r2_q, pm_q, rm_q);
  end

  // The square path sits out the final conversion phase.
  assign sq_start   = mstart_q && (state_q != ST_POST);
  assign phase_done = mu_done && (sq_done || (state_q == ST_POST));

  mmm_serial_unit #(.WIDTH(WIDTH)) u_sq (
    .clk(clk), .rstb(rstb), .ena(ena), .clear(clear), .start(sq_start),
    .a(sq_a), .b(sq_b), .n(mod_q), .r(sq_r), .done(sq_done)
  );

  mmm_serial_unit #(.WIDTH(WIDTH)) u_mu (
    .clk(clk), .rstb(rstb), .ena(ena), .clear(clear), .start(mstart_q),
    .a(mu_a), .b(mu_b), .n(mod_q), .r(mu_r), .done(mu_done)
  );

  always_comb begin
    state_d  = state_q;
    pend_d   = 1'b0;
    mstart_d = 1'b0;
    base_d   = base_q;
    expo_d   = expo_q;
    mod_d    = mod_q;
    r2_d     = r2_q;
    pm_d     = pm_q;
    rm_d     = rm_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        // A captured request is qualified one cycle after the sampling edge.
        if (pend_q) begin
          if (!mod_q[0]) begin
            err_d    = 1'b1;
            done_d   = 1'b1;
            result_d = '0;
          end else begin
            err_d    = 1'b0;
            busy_d   = 1'b1;
            mstart_d = 1'b1;
            state_d  = ST_PRE;
          end
        end else if (start) begin
          base_d = base;
          expo_d = expo;
          mod_d  = modulus;
          r2_d   = r2;
          pend_d = 1'b1;
        end
      end
      ST_PRE: begin
        if (phase_done) begin
          pm_d     = sq_r;
          rm_d     = mu_r;
          mstart_d = 1'b1;
          state_d  = (expo_q == '0) ? ST_POST : ST_LOOP;
        end
      end
      ST_LOOP: begin
        if (phase_done) begin
          pm_d     = sq_r;
          if (expo_q[0]) rm_d = mu_r;
          expo_d   = expo_q >> 1;
          mstart_d = 1'b1;
          state_d  = (expo_q[WIDTH-1:1] == '0) ? ST_POST : ST_LOOP;
        end
      end
      ST_POST: begin
        if (phase_done) begin
          result_d = mu_r;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (clear) begin
      state_d  = ST_IDLE;
      pend_d   = 1'b0;
      mstart_d = 1'b0;
      result_d = '0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= ST_IDLE;
      pend_q   <= 1'b0;
      mstart_q <= 1'b0;
      base_q   <= '0;
      expo_q   <= '0;
      mod_q    <= '0;
      r2_q     <= '0;
      pm_q     <= '0;
      rm_q     <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (ena) begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      mstart_q <= mstart_d;
      base_q   <= base_d;
      expo_q   <= expo_d;
      mod_q    <= mod_d;
      r2_q     <= r2_d;
      pm_q     <= pm_d;
      rm_q     <= rm_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_rsa_modexp_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rsa_modexp_unit : scoreboard bench, directed WIDTH=8 and random WIDTH=16
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_rsa_modexp_unit;

  typedef struct {
    logic [15:0] res;
    logic        err;
    int          edge_no;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int   total = 0;
  int   bad   = 0;
  exp_t q8[$];
  exp_t q16[$];
  exp_t x8, x16;

  logic       rstb8, ena8, clear8, start8;
  logic [7:0] base8, expo8, mod8, r28, result8;
  logic       busy8, done8, err8;

  logic        rstb16, start16;
  logic [15:0] base16, expo16, mod16, r216, result16;
  logic        busy16, done16, err16;

  rsa_modexp_unit #(.WIDTH(8)) u8 (
    .clk(clk), .rstb(rstb8), .ena(ena8), .clear(clear8), .start(start8),
    .base(base8), .expo(expo8), .modulus(mod8), .r2(r28),
    .result(result8), .busy(busy8), .done(done8), .err(err8)
  );

  rsa_modexp_unit #(.WIDTH(16)) u16 (
    .clk(clk), .rstb(rstb16), .ena(1'b1), .clear(1'b0), .start(start16),
    .base(base16), .expo(expo16), .modulus(mod16), .r2(r216),
    .result(result16), .busy(busy16), .done(done16), .err(err16)
  );

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain square-and-multiply modular power.
  function automatic longint modpow(input longint b, input longint e, input longint n);
    longint acc = 1 % n;
    longint p   = b % n;
    while (e > 0) begin
      if (e % 2 == 1) acc = (acc * p) % n;
      p = (p * p) % n;
      e = e / 2;
    end
    return acc;
  endfunction

  // Done edge offset: (bit length of expo + 2) phases of width+3 cycles, plus one.
  function automatic int latency(input int width, input longint e);
    int k = 0;
    while ((e >> k) != 0) k++;
    return (k + 2) * (width + 3) + 1;
  endfunction

  function automatic exp_t expect_of(input int width, input longint b, input longint e,
                                     input longint m, input int s_edge, input int delay);
    exp_t x;
    if (m % 2 == 0) x = '{res: 16'd0, err: 1'b1, edge_no: s_edge + 1};
    else x = '{res: 16'(modpow(b, e, m)), err: 1'b0,
               edge_no: s_edge + latency(width, e) + delay};
    return x;
  endfunction

  always @(negedge clk) begin
    if (rstb8 && done8) begin
      if (q8.size() == 0) chk("u8 unexpected done", done8, 0);
      else begin
        x8 = q8.pop_front();
        chk("u8 result", result8, x8.res);
        chk("u8 err", err8, x8.err);
        chk("u8 done edge", edge_cnt, x8.edge_no);
        chk("u8 busy at done", busy8, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (rstb16 && done16) begin
      if (q16.size() == 0) chk("u16 unexpected done", done16, 0);
      else begin
        x16 = q16.pop_front();
        chk("u16 result", result16, x16.res);
        chk("u16 err", err16, x16.err);
        chk("u16 done edge", edge_cnt, x16.edge_no);
      end
    end
  end

  task automatic issue8(input logic [7:0] b, input logic [7:0] e, input logic [7:0] m,
                        input bit push, input int delay, output int s_edge);
    base8  = b;
    expo8  = e;
    mod8   = m;
    r28    = 8'((64'd1 << 16) % m);
    start8 = 1'b1;
    s_edge = edge_cnt + 1;
    if (push) q8.push_back(expect_of(8, b, e, m, s_edge, delay));
    @(negedge clk);
    start8 = 1'b0;
    base8  = 8'($urandom);
    expo8  = 8'($urandom);
    mod8   = 8'($urandom);
    r28    = 8'($urandom);
  endtask

  task automatic wait_done8();
    int n = 0;
    while (!done8 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!done8) chk("u8 done timeout", done8, 1);
  endtask

  task automatic issue16(input logic [15:0] b, input logic [15:0] e, input logic [15:0] m);
    base16  = b;
    expo16  = e;
    mod16   = m;
    r216    = 16'((64'd1 << 32) % m);
    start16 = 1'b1;
    q16.push_back(expect_of(16, b, e, m, edge_cnt + 1, 0));
    @(negedge clk);
    start16 = 1'b0;
    base16  = 16'($urandom);
    expo16  = 16'($urandom);
    mod16   = 16'($urandom);
  endtask

  task automatic wait_done16();
    int n = 0;
    while (!done16 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!done16) chk("u16 done timeout", done16, 1);
  endtask

  task automatic wait_edge(input int target);
    while (edge_cnt < target) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    rstb8 = 1'b0; ena8 = 1'b1; clear8 = 1'b0; start8 = 1'b0;
    base8 = '0; expo8 = '0; mod8 = '0; r28 = '0;
    rstb16 = 1'b0; start16 = 1'b0;
    base16 = '0; expo16 = '0; mod16 = '0; r216 = '0;
    repeat (3) @(negedge clk);
    chk("reset result", result8, 0);
    chk("reset busy", busy8, 0);
    chk("reset done", done8, 0);
    chk("reset err", err8, 0);
    rstb8 = 1'b1;
    rstb16 = 1'b1;
    @(negedge clk);

    issue8(8'd88, 8'd7, 8'd187, 1, 0, s);   wait_done8();
    issue8(8'd11, 8'd23, 8'd187, 1, 0, s);  wait_done8();
    issue8(8'd5, 8'd0, 8'd187, 1, 0, s);    wait_done8();
    issue8(8'd200, 8'd1, 8'd187, 1, 0, s);  wait_done8();

    issue8(8'd37, 8'd99, 8'd186, 1, 0, s);
    chk("u8 busy on even modulus", busy8, 0);
    wait_done8();
    issue8(8'd88, 8'd7, 8'd187, 1, 0, s);   wait_done8();

    // A start while busy must not disturb the running request.
    issue8(8'd11, 8'd23, 8'd187, 1, 0, s);
    wait_edge(s + 15);
    chk("u8 busy mid-run", busy8, 1);
    base8 = 8'd3; expo8 = 8'd1; mod8 = 8'd187; r28 = 8'd86; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8();

    issue8(8'd88, 8'd7, 8'd187, 0, 0, s);
    wait_edge(s + 29);
    clear8 = 1'b1;
    @(negedge clk);
    clear8 = 1'b0;
    chk("clear busy", busy8, 0);
    chk("clear result", result8, 0);
    chk("clear done", done8, 0);
    chk("clear err", err8, 0);
    repeat (80) @(negedge clk);

    issue8(8'd3, 8'd5, 8'd187, 1, 10, s);
    wait_edge(s + 20);
    ena8 = 1'b0;
    repeat (10) @(negedge clk);
    ena8 = 1'b1;
    wait_done8();

    issue8(8'd11, 8'd23, 8'd187, 0, 0, s);
    wait_edge(s + 25);
    @(posedge clk);
    #2 rstb8 = 1'b0;
    #1;
    chk("async reset result", result8, 0);
    chk("async reset busy", busy8, 0);
    chk("async reset done", done8, 0);
    chk("async reset err", err8, 0);
    @(negedge clk);
    rstb8 = 1'b1;
    @(negedge clk);
    issue8(8'd5, 8'd0, 8'd187, 1, 0, s);    wait_done8();

    for (int i = 0; i < 12; i++) begin
      logic [15:0] m, b, e;
      m = 16'($urandom) | 16'd1;
      if (m < 16'd3) m = 16'd3;
      if (i % 5 == 4) m[0] = 1'b0;
      b = 16'($urandom);
      e = (i < 3) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      issue16(b, e, m);
      wait_done16();
    end

    repeat (5) @(negedge clk);
    chk("u8 queue drained", q8.size(), 0);
    chk("u16 queue drained", q16.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rsa_modexp_unit.md
# rsa_modexp_unit

Parametrised modular-exponentiation engine computing result = base^expo mod modulus with Montgomery arithmetic. It is the handshake-driven successor of the fixed-width RSA datapath. It adds a start/busy/done protocol, input capture, early termination on the highest set exponent bit, an even-modulus error check and a synchronous abort. The engine sits behind the SPI/register front end. It uses two parallel bit-serial Montgomery multipliers: one for squaring and one for multiplying.

## Interface
- WIDTH, default 8: operand width in bits (≥4); Montgomery radix R = 2^WIDTH.
- clk  in  1  rising-edge clock
- rstb  in  1  asynchronous active-low reset
- ena  in  1  global enable; low freezes all state, outputs hold
- clear  in  1  synchronous abort, active high, effective only when ena=1
- start  in  1  request; sampled on an edge where ena=1 and busy=0
- base  in  WIDTH  message/base, any value
- expo  in  WIDTH  exponent
- modulus  in  WIDTH  modulus N; must be odd
- r2  in  WIDTH  precomputed 2^(2·WIDTH) mod N; must be < N
- result  out  WIDTH  final value, valid from done until the next accepted start or clear
- busy  out  1  computation in progress
- done  out  1  one-cycle completion pulse
- err  out  1  set when the last request had an even modulus

## Operation
- Reset values: result=0, busy=0, done=0, err=0, FSM in IDLE.
- On the sampling edge, base, expo, modulus and r2 are captured. Inputs may change afterwards.
- If modulus[0]=0: err=1, done=1 on the next edge, result=0, return to IDLE.
- Otherwise: err=0, busy=1.
- FSM sequence: IDLE → PRE → LOOP → POST → IDLE.
- Each phase: 1 issue cycle followed by one multiplier run of WIDTH+2 cycles. Phase length P = WIDTH+3.
- PRE: both multipliers run in parallel.
  - Square path: Pm = mont(base, r2) = base·R mod N.
  - Multiply path: Rm = mont(1, r2) = R mod N.
- LOOP: one round per exponent bit, LSB first.
  - Pm ← mont(Pm, Pm) every round.
  - Rm ← mont(Rm, Pm_old) only if the current bit is 1; otherwise Rm holds.
  - The exponent register shifts right each round. LOOP exits when the remaining exponent is 0.
  - expo=0 skips LOOP entirely.
- POST: result ← mont(1, Rm). done=1 and busy=0 on the final edge.
- mont(A,B) = A·B·2^-WIDTH mod N. Bit-serial: S←(S + a_i·B + q·N)/2 with q = LSB of (S + a_i·B), for WIDTH iterations, then one conditional-subtract cycle.
  - The accumulator is WIDTH+2 bits.
  - The output is always < N when B < N.
- start while busy=1 is ignored.
- clear=1: return to IDLE; busy, done, err and result return to reset values. clear wins over a simultaneous start.
- r2 ≥ N: result undefined, no error flagged.

## Timing
- k = index of the highest set bit of expo + 1; k=0 for expo=0.
- Normal latency: done rises on edge (k+2)·P + 1, counting the sampling edge as edge 0.
- busy is high from edge 1 up to that edge.
- Error latency: done and err rise on edge 1; busy never asserts.
- done is high for exactly one enabled cycle. While ena=0, done and every counter hold.
- A new start is accepted on the edge where done is high. done and busy change together.
- Latency does not depend on the number of 1 bits in expo, only on k.

## Structure
- Shared package rsa_pkg:
  - FSM state enum (IDLE, PRE, LOOP, POST).
  - Operand-select encoding for the multiplier inputs.
  - Function computing the phase length from WIDTH.
- Sub-module mmm_serial_unit #(WIDTH): ports clk, rstb, ena, clear, start, a, b, n, r, done.
  - Fixed latency of WIDTH+2 edges from start to done.
  - Instantiated twice: square path and multiply path.
- The top level holds the FSM, the captured operand registers, the exponent shift register and the result register.

## Test plan
- WIDTH=8, N=187, r2=86, base=88, expo=7 → result=11, err=0, done on edge 56.
- Same N and r2, base=11, expo=23 → result=88, done on edge 78.
- expo=0, N=187, base=5 → result=1, done on edge 23. base=200 (≥N), expo=1 → result=13.
- modulus=186 → err=1, done on edge 1, result=0, busy stays 0. The next odd request clears err.
- Control-signal corner cases:
  - start pulsed while busy: no effect.
  - clear at edge 30 of a run: busy=0 next cycle, result=0, no done.
  - ena low for 10 cycles mid-run: done is delayed by exactly 10 cycles and the result is unchanged.
- Reset asserted mid-run: all outputs return to 0 immediately. Random WIDTH=16 vectors are checked against a software pow(b,e,N) model.
